// File: rtl/stage_writeback_vec.sv
// Vector memory/writeback stage: one transaction per cycle over valid/ready.
// Stores masked lanes to the local vector memory or emits a writeback vector.
module stage_writeback_vec #(
    parameter int VEC_SIZE  = 4,
    parameter int REG_SIZE  = 16,
    parameter int MEM_DATA  = 8,
    parameter int MEM_DEPTH = 256,
    parameter int RD_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         is_store,
    input  logic [1:0]                   wb_sel,
    input  logic [VEC_SIZE-1:0]          lane_mask,
    input  logic [RD_W-1:0]              rd_in,
    input  logic [REG_SIZE-1:0]          imm,
    input  logic [VEC_SIZE*REG_SIZE-1:0] alu_result,
    input  logic [VEC_SIZE*REG_SIZE-1:0] alu_operand1,
    input  logic [VEC_SIZE*REG_SIZE-1:0] alu_operand2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [VEC_SIZE*REG_SIZE-1:0] wb_data,
    output logic [RD_W-1:0]              wb_rd,
    output logic                         wb_en,
    output logic                         addr_error
);

    localparam int VW     = VEC_SIZE * REG_SIZE;
    localparam int MW     = VEC_SIZE * MEM_DATA;
    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [REG_SIZE:0] DEPTH_LIM = (REG_SIZE + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        SEL_MEMZ = 2'd0,
        SEL_MEMS = 2'd1,
        SEL_ALU  = 2'd2,
        SEL_IMM  = 2'd3
    } wbSel_t;

    typedef struct packed {
        logic                isStore;
        wbSel_t              sel;
        logic [VEC_SIZE-1:0] mask;
        logic [RD_W-1:0]     rd;
        logic                en;
        logic                err;
        logic [REG_SIZE-1:0] immVal;
        logic [VW-1:0]       alu;
    } outSlot_t;

    logic [MW-1:0]       mem [MEM_DEPTH];
    logic [MW-1:0]       rdWord;
    logic                outValidQ;
    outSlot_t            slotQ;
    outSlot_t            slotD;
    logic                accept;
    logic [REG_SIZE-1:0] addr;
    logic                addrErr;
    logic [ADDR_W-1:0]   memIdx;
    logic                memWe;
    logic                memRe;
    logic [MEM_DATA-1:0] elem;
    logic [REG_SIZE-1:0] laneVal;
    logic [VW-1:0]       wbDataC;

    assign in_ready = !outValidQ || out_ready;
    assign accept   = in_valid && in_ready;

    assign addr    = is_store ? alu_operand2[REG_SIZE-1:0] : imm;
    assign addrErr = {1'b0, addr} >= DEPTH_LIM;
    assign memIdx  = addr[ADDR_W-1:0];

    // Memory ports only fire on accept and never while reset is held.
    assign memWe = reset && accept && is_store && !addrErr;
    assign memRe = reset && accept && !is_store && !wb_sel[1] && !addrErr;

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < VEC_SIZE; i++) begin
                if (lane_mask[i]) begin
                    mem[memIdx][i*MEM_DATA +: MEM_DATA] <=
                        alu_operand1[i*REG_SIZE +: MEM_DATA];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (memRe) begin
            rdWord <= mem[memIdx];
        end
    end

    always_comb begin
        slotD         = '0;
        slotD.isStore = is_store;
        slotD.sel     = wbSel_t'(wb_sel);
        slotD.mask    = lane_mask;
        slotD.rd      = rd_in;
        slotD.en      = !is_store;
        slotD.err     = addrErr;
        slotD.immVal  = imm;
        slotD.alu     = alu_result;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outValidQ <= 1'b0;
            slotQ     <= '0;
        end else if (accept) begin
            outValidQ <= 1'b1;
            slotQ     <= slotD;
        end else if (out_ready) begin
            outValidQ <= 1'b0;
        end
    end

    // Lane formatting happens after the register so the memory read stays synchronous.
    always_comb begin
        wbDataC = '0;
        elem    = '0;
        laneVal = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            elem    = rdWord[i*MEM_DATA +: MEM_DATA];
            laneVal = '0;
            unique case (slotQ.sel)
                SEL_MEMZ: begin
                    laneVal[MEM_DATA-1:0] = elem;
                    if (slotQ.err) laneVal = '0;
                end
                SEL_MEMS: begin
                    laneVal[MEM_DATA-1:0] = elem;
                    for (int b = MEM_DATA; b < REG_SIZE; b++) begin
                        laneVal[b] = elem[MEM_DATA-1];
                    end
                    if (slotQ.err) laneVal = '0;
                end
                SEL_ALU: laneVal = slotQ.alu[i*REG_SIZE +: REG_SIZE];
                SEL_IMM: laneVal = slotQ.immVal;
                default: laneVal = '0;
            endcase
            if (!outValidQ || slotQ.isStore || !slotQ.mask[i]) begin
                laneVal = '0;
            end
            wbDataC[i*REG_SIZE +: REG_SIZE] = laneVal;
        end
    end

    assign out_valid  = outValidQ;
    assign wb_data    = wbDataC;
    assign wb_rd      = slotQ.rd;
    assign wb_en      = outValidQ && slotQ.en;
    assign addr_error = outValidQ && slotQ.err;

endmodule

// File: tb/tb_stage_writeback_vec.sv
// Directed bench for stage_writeback_vec: vector table plus stall/reset sequences.
module tb_stage_writeback_vec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        is_store;
    logic [1:0]  wb_sel;
    logic [3:0]  lane_mask;
    logic [3:0]  rd_in;
    logic [15:0] imm;
    logic [63:0] alu_result;
    logic [63:0] alu_operand1;
    logic [63:0] alu_operand2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_en;
    logic        addr_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_writeback_vec #(
        .VEC_SIZE(4), .REG_SIZE(16), .MEM_DATA(8), .MEM_DEPTH(256), .RD_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_store(is_store), .wb_sel(wb_sel), .lane_mask(lane_mask),
        .rd_in(rd_in), .imm(imm), .alu_result(alu_result),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
        .addr_error(addr_error)
    );

    typedef struct {
        logic        st;
        logic [1:0]  sel;
        logic [3:0]  mask;
        logic [3:0]  rd;
        logic [15:0] immV;
        logic [63:0] alu;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] expData;
        logic        expEn;
        logic        expErr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] v4(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(
        input logic st, input logic [1:0] sel, input logic [3:0] mask,
        input logic [3:0] rd, input logic [15:0] immV,
        input logic [63:0] alu, op1, op2, expData,
        input logic expErr
    );
        vec_t v;
        v.st = st; v.sel = sel; v.mask = mask; v.rd = rd; v.immV = immV;
        v.alu = alu; v.op1 = op1; v.op2 = op2; v.expData = expData;
        v.expEn = !st; v.expErr = expErr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        in_valid     = 1'b1;
        is_store     = v.st;
        wb_sel       = v.sel;
        lane_mask    = v.mask;
        rd_in        = v.rd;
        imm          = v.immV;
        alu_result   = v.alu;
        alu_operand1 = v.op1;
        alu_operand2 = v.op2;
    endtask

    task automatic chkOut(input string tag, input vec_t v);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".data"}, wb_data, v.expData);
        chk({tag, ".rd"}, 64'(wb_rd), 64'(v.rd));
        chk({tag, ".en"}, 64'(wb_en), 64'(v.expEn));
        chk({tag, ".err"}, 64'(addr_error), 64'(v.expErr));
    endtask

    // First transaction is held by a 3-cycle stall while the second waits.
    task automatic stallSeq(input string tag, input vec_t a, input vec_t b);
        out_ready = 1'b0;
        apply(a);
        @(posedge clk); #1;
        chkOut({tag, ".a"}, a);
        apply(b);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s.hold%0d.ready", tag, k), 64'(in_ready), 64'd0);
            chkOut($sformatf("%s.hold%0d", tag, k), a);
        end
        out_ready = 1'b1;
        #1;
        chk({tag, ".release.ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chkOut({tag, ".b"}, b);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t s1, s2;
        reset = 1'b0;
        in_valid = 1'b0; is_store = 1'b0; wb_sel = 2'd0; lane_mask = 4'h0;
        rd_in = 4'h0; imm = 16'h0; alu_result = '0;
        alu_operand1 = '0; alu_operand2 = '0; out_ready = 1'b1;

        tbl.push_back(mk(1, 0, 4'hF, 1, 0, 0, v4(16'h5A11, 16'h22, 16'h33, 16'hFF44),
                         v4(5, 0, 0, 0), 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 2, 5, 0, 0, 0, v4(16'h11, 16'h22, 16'h33, 16'h44), 0));
        tbl.push_back(mk(1, 0, 4'hF, 3, 0, 0, v4(16'h80, 16'h7F, 16'h01, 16'hFE),
                         v4(7, 16'hFF, 3, 0), 0, 0));
        tbl.push_back(mk(0, 1, 4'hF, 4, 7, 0, 0, 0,
                         v4(16'hFF80, 16'h007F, 16'h0001, 16'hFFFE), 0));
        tbl.push_back(mk(0, 0, 4'hF, 5, 7, 0, 0, 0,
                         v4(16'h0080, 16'h007F, 16'h0001, 16'h00FE), 0));
        tbl.push_back(mk(1, 2, 4'hF, 6, 0, v4(1, 2, 3, 4), 0, v4(9, 0, 0, 0), 0, 0));
        tbl.push_back(mk(1, 0, 4'h5, 7, 0, 0, v4(16'hAA, 16'hBB, 16'hCC, 16'hDD),
                         v4(9, 0, 0, 0), 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 8, 9, 0, 0, 0, v4(16'hAA, 0, 16'hCC, 0), 0));
        tbl.push_back(mk(0, 0, 4'h3, 9, 9, 0, 0, 0, v4(16'hAA, 0, 0, 0), 0));
        tbl.push_back(mk(0, 2, 4'hF, 10, 0, v4(1, 2, 3, 4), 0, 0, v4(1, 2, 3, 4), 0));
        tbl.push_back(mk(0, 2, 4'hA, 11, 0, v4(1, 2, 3, 4), 0, 0, v4(0, 2, 0, 4), 0));
        tbl.push_back(mk(0, 3, 4'hD, 12, 16'hBEEF, 0, 0, 0,
                         v4(16'hBEEF, 0, 16'hBEEF, 16'hBEEF), 1));
        tbl.push_back(mk(1, 0, 4'hF, 13, 0, 0, v4(1, 2, 3, 4), v4(44, 0, 0, 0), 0, 0));
        tbl.push_back(mk(1, 0, 4'hF, 14, 0, 0, v4(16'h55, 16'h66, 16'h77, 16'h88),
                         v4(300, 0, 0, 0), 0, 1));
        tbl.push_back(mk(0, 1, 4'hF, 15, 44, 0, 0, 0, v4(1, 2, 3, 4), 0));
        tbl.push_back(mk(0, 0, 4'hF, 0, 300, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'hF, 1, 300, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'hF, 2, 0, 0, v4(9, 8, 7, 6), v4(255, 0, 0, 0), 0, 0));
        tbl.push_back(mk(0, 0, 4'hF, 3, 255, 0, 0, 0, v4(9, 8, 7, 6), 0));
        tbl.push_back(mk(0, 0, 4'hF, 4, 256, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 5, 5, 0, 0, 0, 0, 0));

        @(posedge clk); @(posedge clk); #1;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.en", 64'(wb_en), 64'd0);
        chk("rst.err", 64'(addr_error), 64'd0);
        chk("rst.data", wb_data, 64'd0);
        chk("rst.rd", 64'(wb_rd), 64'd0);
        reset = 1'b1;
        #1;
        chk("rst.ready", 64'(in_ready), 64'd1);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(posedge clk); #1;
            chkOut($sformatf("v%0d", i), tbl[i]);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle.valid", 64'(out_valid), 64'd0);

        s1 = mk(0, 0, 4'hF, 6, 5, 0, 0, 0, v4(16'h11, 16'h22, 16'h33, 16'h44), 0);
        s2 = mk(0, 0, 4'hF, 7, 7, 0, 0, 0, v4(16'h80, 16'h7F, 16'h01, 16'hFE), 0);
        stallSeq("stl_ld", s1, s2);
        s1 = mk(0, 2, 4'hF, 8, 0, v4(1, 2, 3, 4), 0, 0, v4(1, 2, 3, 4), 0);
        s2 = mk(0, 3, 4'hF, 9, 16'h1234, 0, 0, 0,
                v4(16'h1234, 16'h1234, 16'h1234, 16'h1234), 1);
        stallSeq("stl_alu", s1, s2);

        out_ready = 1'b0;
        s1 = mk(0, 2, 4'hF, 7, 300, v4(5, 6, 7, 8), 0, 0, v4(5, 6, 7, 8), 1);
        apply(s1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chkOut("ar.pre", s1);
        #2 reset = 1'b0;
        #1;
        chk("ar.valid", 64'(out_valid), 64'd0);
        chk("ar.en", 64'(wb_en), 64'd0);
        chk("ar.data", wb_data, 64'd0);
        chk("ar.rd", 64'(wb_rd), 64'd0);
        chk("ar.err", 64'(addr_error), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("ar.ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        s1 = mk(0, 0, 4'hF, 3, 5, 0, 0, 0, v4(16'h11, 16'h22, 16'h33, 16'h44), 0);
        apply(s1);
        @(posedge clk); #1;
        chkOut("ar.mem", s1);
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
